// File: rtl/alu_driver.sv
// Sequencer for an external combinational 4-bit ALU: registers a command, holds
// the ALU inputs stable for SETTLE_CYCLES cycles, then captures the result.
module alu_driver #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_op,
   input  logic [3:0] cmd_a,
   input  logic [3:0] cmd_b,
   input  logic       cmd_use_acc,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic       alu_l,
   output logic       alu_m,
   output logic       alu_n,
   input  logic [3:0] alu_s,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [3:0] res_data,
   output logic [2:0] res_op,
   output logic       res_zero
);

   localparam int unsigned DATA_W = 4;
   localparam int unsigned OP_W   = 3;
   localparam int unsigned CNT_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   state_t              r_state,     w_state_nxt;
   logic [CNT_W-1:0]    r_cnt,       w_cnt_nxt;
   logic [DATA_W-1:0]   r_acc,       w_acc_nxt;
   logic [DATA_W-1:0]   r_alu_a,     w_alu_a_nxt;
   logic [DATA_W-1:0]   r_alu_b,     w_alu_b_nxt;
   logic [OP_W-1:0]     r_alu_op,    w_alu_op_nxt;
   logic                r_cmd_ready, w_cmd_ready_nxt;
   logic                r_res_valid, w_res_valid_nxt;
   logic [DATA_W-1:0]   r_res_data,  w_res_data_nxt;
   logic [OP_W-1:0]     r_res_op,    w_res_op_nxt;
   logic                r_res_zero,  w_res_zero_nxt;
   logic                w_settled;

   // The ALU operand registers double as the in-flight command.
   assign w_settled = (r_cnt == CNT_W'(SETTLE_CYCLES - 1));

   // State register plus every registered output.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_acc       <= '0;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_op    <= '0;
         r_cmd_ready <= 1'b1;
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
         r_res_op    <= '0;
         r_res_zero  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_acc       <= w_acc_nxt;
         r_alu_a     <= w_alu_a_nxt;
         r_alu_b     <= w_alu_b_nxt;
         r_alu_op    <= w_alu_op_nxt;
         r_cmd_ready <= w_cmd_ready_nxt;
         r_res_valid <= w_res_valid_nxt;
         r_res_data  <= w_res_data_nxt;
         r_res_op    <= w_res_op_nxt;
         r_res_zero  <= w_res_zero_nxt;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_acc_nxt       = r_acc;
      w_alu_a_nxt     = r_alu_a;
      w_alu_b_nxt     = r_alu_b;
      w_alu_op_nxt    = r_alu_op;
      w_cmd_ready_nxt = r_cmd_ready;
      w_res_valid_nxt = r_res_valid;
      w_res_data_nxt  = r_res_data;
      w_res_op_nxt    = r_res_op;
      w_res_zero_nxt  = r_res_zero;
      case (r_state)
         ST_IDLE: begin
            if (cmd_valid && r_cmd_ready) begin
               w_alu_a_nxt     = cmd_use_acc ? r_acc : cmd_a;
               w_alu_b_nxt     = cmd_b;
               w_alu_op_nxt    = cmd_op;
               w_cnt_nxt       = '0;
               w_cmd_ready_nxt = 1'b0;
               w_state_nxt     = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            if (w_settled) begin
               w_res_data_nxt  = alu_s;
               w_acc_nxt       = alu_s;
               w_res_op_nxt    = r_alu_op;
               w_res_zero_nxt  = (alu_s == DATA_W'(0));
               w_res_valid_nxt = 1'b1;
               w_alu_a_nxt     = '0;
               w_alu_b_nxt     = '0;
               w_alu_op_nxt    = '0;
               w_cnt_nxt       = '0;
               w_state_nxt     = ST_RESP;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (res_ready) begin
               w_res_valid_nxt = 1'b0;
               w_cmd_ready_nxt = 1'b1;
               w_state_nxt     = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt     = ST_IDLE;
            w_cmd_ready_nxt = 1'b1;
            w_res_valid_nxt = 1'b0;
         end
      endcase
   end

   assign cmd_ready = r_cmd_ready;
   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign alu_l     = r_alu_op[2];
   assign alu_m     = r_alu_op[1];
   assign alu_n     = r_alu_op[0];
   assign res_valid = r_res_valid;
   assign res_data  = r_res_data;
   assign res_op    = r_res_op;
   assign res_zero  = r_res_zero;

endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver: one instance with SETTLE_CYCLES=1, one with 3,
// each wired to a behavioural combinational ALU.
module tb_alu_driver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   int   errors = 0;
   int   checks = 0;

   logic       c0_valid, c0_ready, c0_use_acc;
   logic [2:0] c0_op;
   logic [3:0] c0_a, c0_b;
   logic [3:0] a0_a, a0_b, a0_s;
   logic       a0_l, a0_m, a0_n;
   logic       r0_valid, r0_ready, r0_zero;
   logic [3:0] r0_data;
   logic [2:0] r0_op;

   logic       c3_valid, c3_ready, c3_use_acc;
   logic [2:0] c3_op;
   logic [3:0] c3_a, c3_b;
   logic [3:0] a3_a, a3_b, a3_s;
   logic       a3_l, a3_m, a3_n;
   logic       r3_valid, r3_ready, r3_zero;
   logic [3:0] r3_data;
   logic [2:0] r3_op;

   function automatic logic [3:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      logic [7:0] p;
      p = a * b;
      case (op)
         3'b000:  return 4'd0 - a;
         3'b001:  return 4'd0 - b;
         3'b010:  return a + b;
         3'b011:  return a - b;
         3'b100:  return a & b;
         3'b101:  return a | b;
         3'b110:  return p[3:0];
         default: return a ^ b;
      endcase
   endfunction

   assign a0_s = alu_f({a0_l, a0_m, a0_n}, a0_a, a0_b);
   assign a3_s = alu_f({a3_l, a3_m, a3_n}, a3_a, a3_b);

   alu_driver #(.SETTLE_CYCLES(1)) u_dut1 (
      .clk(clk), .reset(reset),
      .cmd_valid(c0_valid), .cmd_ready(c0_ready), .cmd_op(c0_op),
      .cmd_a(c0_a), .cmd_b(c0_b), .cmd_use_acc(c0_use_acc),
      .alu_a(a0_a), .alu_b(a0_b), .alu_l(a0_l), .alu_m(a0_m), .alu_n(a0_n),
      .alu_s(a0_s), .res_valid(r0_valid), .res_ready(r0_ready),
      .res_data(r0_data), .res_op(r0_op), .res_zero(r0_zero)
   );

   alu_driver #(.SETTLE_CYCLES(3)) u_dut3 (
      .clk(clk), .reset(reset),
      .cmd_valid(c3_valid), .cmd_ready(c3_ready), .cmd_op(c3_op),
      .cmd_a(c3_a), .cmd_b(c3_b), .cmd_use_acc(c3_use_acc),
      .alu_a(a3_a), .alu_b(a3_b), .alu_l(a3_l), .alu_m(a3_m), .alu_n(a3_n),
      .alu_s(a3_s), .res_valid(r3_valid), .res_ready(r3_ready),
      .res_data(r3_data), .res_op(r3_op), .res_zero(r3_zero)
   );

   // Full command on the SETTLE_CYCLES=1 instance; called at a negedge with the DUT idle.
   task automatic run1(input string name, input logic [2:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic use_acc,
                       input logic [3:0] exp_a, input logic [3:0] exp_res);
      logic [3:0] zero4;
      zero4      = 4'd0;
      c0_valid   = 1'b1;
      c0_op      = op;
      c0_a       = a;
      c0_b       = b;
      c0_use_acc = use_acc;
      r0_ready   = 1'b1;
      @(negedge clk);
      c0_valid   = 1'b0;
      c0_op      = ~op;
      c0_a       = ~a;
      c0_b       = ~b;
      c0_use_acc = ~use_acc;
      checks++;
      if ({a0_a, a0_b, a0_l, a0_m, a0_n, c0_ready, r0_valid} !== {exp_a, b, op, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL %s_drive: alu_a=%0d alu_b=%0d op=%b rdy=%b vld=%b, want alu_a=%0d alu_b=%0d op=%b rdy=0 vld=0",
                  name, a0_a, a0_b, {a0_l, a0_m, a0_n}, c0_ready, r0_valid, exp_a, b, op);
      end
      @(negedge clk);
      checks++;
      if ({r0_valid, r0_data, r0_op, r0_zero} !== {1'b1, exp_res, op, (exp_res == zero4)}) begin
         errors++;
         $display("FAIL %s_result: vld=%b data=%0d op=%b zero=%b, want vld=1 data=%0d op=%b zero=%b",
                  name, r0_valid, r0_data, r0_op, r0_zero, exp_res, op, (exp_res == zero4));
      end
      checks++;
      if ({a0_a, a0_b, a0_l, a0_m, a0_n} !== 11'd0) begin
         errors++;
         $display("FAIL %s_alu_idle: alu bus=%h, want 0", name, {a0_a, a0_b, a0_l, a0_m, a0_n});
      end
      @(negedge clk);
      checks++;
      if ({r0_valid, c0_ready} !== 2'b01) begin
         errors++;
         $display("FAIL %s_release: vld=%b rdy=%b, want vld=0 rdy=1", name, r0_valid, c0_ready);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      c0_valid = 1'b0; c0_op = 3'd0; c0_a = 4'd0; c0_b = 4'd0; c0_use_acc = 1'b0; r0_ready = 1'b0;
      c3_valid = 1'b0; c3_op = 3'd0; c3_a = 4'd0; c3_b = 4'd0; c3_use_acc = 1'b0; r3_ready = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({c0_ready, r0_valid, r0_data, r0_op, r0_zero} !== {1'b1, 1'b0, 4'd0, 3'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_res: rdy=%b vld=%b data=%0d op=%b zero=%b, want rdy=1 vld=0 data=0 op=000 zero=0",
                  c0_ready, r0_valid, r0_data, r0_op, r0_zero);
      end
      checks++;
      if ({a0_a, a0_b, a0_l, a0_m, a0_n} !== 11'd0) begin
         errors++;
         $display("FAIL reset_alu: alu bus=%h, want 0", {a0_a, a0_b, a0_l, a0_m, a0_n});
      end
      checks++;
      if ({c3_ready, r3_valid, a3_a, a3_b, a3_l, a3_m, a3_n} !== {1'b1, 12'd0}) begin
         errors++;
         $display("FAIL reset_dut3: rdy=%b vld=%b alu bus=%h, want rdy=1 vld=0 alu bus=0",
                  c3_ready, r3_valid, {a3_a, a3_b, a3_l, a3_m, a3_n});
      end
   endtask

   task automatic test_add();
      run1("add", 3'b010, 4'd5, 4'd3, 1'b0, 4'd5, 4'd8);
   endtask

   task automatic test_sub_wrap();
      run1("sub_wrap", 3'b011, 4'd3, 4'd5, 1'b0, 4'd3, 4'd14);
      run1("neg_zero", 3'b000, 4'd0, 4'd7, 1'b0, 4'd0, 4'd0);
   endtask

   task automatic test_acc_chain();
      run1("acc_load", 3'b010, 4'd7, 4'd0, 1'b0, 4'd7, 4'd7);
      run1("acc_add",  3'b010, 4'd2, 4'd6, 1'b1, 4'd7, 4'd13);
      run1("acc_mul",  3'b110, 4'd1, 4'd3, 1'b1, 4'd13, 4'd7);
   endtask

   task automatic test_backpressure();
      c0_valid = 1'b1; c0_op = 3'b100; c0_a = 4'd12; c0_b = 4'd10; c0_use_acc = 1'b0;
      r0_ready = 1'b0;
      @(negedge clk);
      c0_op = 3'b101; c0_a = 4'd1; c0_b = 4'd2;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({r0_valid, r0_data, r0_op, c0_ready, a0_a} !== {1'b1, 4'd8, 3'b100, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL bp_hold%0d: vld=%b data=%0d op=%b rdy=%b alu_a=%0d, want vld=1 data=8 op=100 rdy=0 alu_a=0",
                     i, r0_valid, r0_data, r0_op, c0_ready, a0_a);
         end
         @(negedge clk);
      end
      r0_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({r0_valid, c0_ready} !== 2'b01) begin
         errors++;
         $display("FAIL bp_release: vld=%b rdy=%b, want vld=0 rdy=1", r0_valid, c0_ready);
      end
      @(negedge clk);
      c0_valid = 1'b0;
      checks++;
      if ({c0_ready, a0_a, a0_b, a0_l, a0_m, a0_n} !== {1'b0, 4'd1, 4'd2, 3'b101}) begin
         errors++;
         $display("FAIL bp_accept: rdy=%b alu_a=%0d alu_b=%0d op=%b, want rdy=0 alu_a=1 alu_b=2 op=101",
                  c0_ready, a0_a, a0_b, {a0_l, a0_m, a0_n});
      end
      @(negedge clk);
      checks++;
      if ({r0_valid, r0_data, r0_op} !== {1'b1, 4'd3, 3'b101}) begin
         errors++;
         $display("FAIL bp_result: vld=%b data=%0d op=%b, want vld=1 data=3 op=101", r0_valid, r0_data, r0_op);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_op();
      c0_valid = 1'b1; c0_op = 3'b101; c0_a = 4'd9; c0_b = 4'd6; c0_use_acc = 1'b0;
      r0_ready = 1'b1;
      @(negedge clk);
      c0_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if ({r0_valid, c0_ready, r0_data, a0_a, a0_b} !== {1'b0, 1'b1, 12'd0}) begin
         errors++;
         $display("FAIL rst_mid: vld=%b rdy=%b data=%0d alu_a=%0d alu_b=%0d, want vld=0 rdy=1 data=0 alu_a=0 alu_b=0",
                  r0_valid, c0_ready, r0_data, a0_a, a0_b);
      end
      run1("rst_acc", 3'b111, 4'd4, 4'd5, 1'b1, 4'd0, 4'd5);
   endtask

   task automatic test_settle3();
      c3_valid = 1'b1; c3_op = 3'b010; c3_a = 4'd9; c3_b = 4'd9; c3_use_acc = 1'b0;
      r3_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         c3_valid = 1'b0;
         c3_a = 4'd1; c3_b = 4'd1; c3_op = 3'b111;
         checks++;
         if ({a3_a, a3_b, a3_l, a3_m, a3_n, r3_valid, c3_ready} !== {4'd9, 4'd9, 3'b010, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL s3_hold%0d: alu_a=%0d alu_b=%0d op=%b vld=%b rdy=%b, want alu_a=9 alu_b=9 op=010 vld=0 rdy=0",
                     i, a3_a, a3_b, {a3_l, a3_m, a3_n}, r3_valid, c3_ready);
         end
      end
      @(negedge clk);
      checks++;
      if ({r3_valid, r3_data, r3_op, r3_zero, a3_a, a3_b} !== {1'b1, 4'd2, 3'b010, 1'b0, 8'd0}) begin
         errors++;
         $display("FAIL s3_result: vld=%b data=%0d op=%b zero=%b alu_a=%0d alu_b=%0d, want vld=1 data=2 op=010 zero=0 alu 0",
                  r3_valid, r3_data, r3_op, r3_zero, a3_a, a3_b);
      end
      @(negedge clk);
      checks++;
      if ({r3_valid, c3_ready} !== 2'b01) begin
         errors++;
         $display("FAIL s3_release: vld=%b rdy=%b, want vld=0 rdy=1", r3_valid, c3_ready);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub_wrap();
      test_acc_chain();
      test_backpressure();
      test_reset_mid_op();
      test_settle3();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
